// File: rtl/m72_gfx_fetch_arb.sv
// m72_gfx_fetch_arb: round-robin arbiter sharing one gfx ROM read port between tilemap layers A and B, with response watchdog.
// Optional wait/timeout statistics are enabled by defining M72_GFX_ARB_STATS_EN.
module m72_gfx_fetch_arb #(
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 63
) (
    input  logic              CLK_32M,
    input  logic              reset,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_busy,
    output logic [DATA_W-1:0] a_data,
    output logic              a_valid,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_busy,
    output logic [DATA_W-1:0] b_data,
    output logic              b_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_valid,
    output logic              timeout_err
`ifdef M72_GFX_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_a_wait,
    output logic [15:0]       stat_b_wait,
    output logic [7:0]        stat_timeouts
`endif
);
    localparam int CW = $clog2(TIMEOUT);
    // Fires so the dummy response appears TIMEOUT cycles after the ack cycle.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_n;
    logic pend_a, pend_b, own, last_grant, active, grant, pick, done, tmo, fin, take_a, take_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [CW-1:0] cnt;
    always_comb begin
        active  = state != IDLE;
        a_busy  = pend_a || (active && !own);
        b_busy  = pend_b || (active && own);
        take_a  = a_req && !a_busy;
        take_b  = b_req && !b_busy;
        grant   = state == IDLE && (pend_a || pend_b);
        pick    = (pend_a && pend_b) ? !last_grant : pend_b;
        done    = mem_valid && ((state == ISSUE && mem_ack) || state == WAIT);
        tmo     = state == WAIT && !mem_valid && cnt == CNT_LAST;
        fin     = done || tmo;
        state_n = grant ? ISSUE : fin ? IDLE : (state == ISSUE && mem_ack) ? WAIT : state;
    end
    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            state       <= IDLE;
            pend_a      <= 1'b0;
            pend_b      <= 1'b0;
            addr_a      <= '0;
            addr_b      <= '0;
            own         <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            a_data      <= '0;
            b_data      <= '0;
            a_valid     <= 1'b0;
            b_valid     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state  <= state_n;
            pend_a <= take_a || (pend_a && !(grant && !pick));
            pend_b <= take_b || (pend_b && !(grant && pick));
            if (take_a) addr_a <= a_addr;
            if (take_b) addr_b <= b_addr;
            if (grant) begin
                own        <= pick;
                last_grant <= pick;
                mem_addr   <= pick ? addr_b : addr_a;
            end
            mem_req <= grant || (mem_req && !(state == ISSUE && mem_ack));
            if (state == ISSUE && mem_ack && !mem_valid) cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;
            a_valid     <= fin && !own;
            b_valid     <= fin && own;
            timeout_err <= tmo;
            if (fin && !own) a_data <= tmo ? '0 : mem_data;
            if (fin && own) b_data <= tmo ? '0 : mem_data;
        end
    end
`ifdef M72_GFX_ARB_STATS_EN
    always_ff @(posedge CLK_32M) begin
        if (reset || stat_clr) begin
            stat_a_wait   <= '0;
            stat_b_wait   <= '0;
            stat_timeouts <= '0;
        end else begin
            if (pend_a && !(active && !own) && stat_a_wait != '1) stat_a_wait <= stat_a_wait + 1'b1;
            if (pend_b && !(active && own) && stat_b_wait != '1) stat_b_wait <= stat_b_wait + 1'b1;
            if (timeout_err && stat_timeouts != '1) stat_timeouts <= stat_timeouts + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_m72_gfx_fetch_arb.sv
// tb_m72_gfx_fetch_arb: scoreboard bench for m72_gfx_fetch_arb with a behavioural memory responder.
module tb_m72_gfx_fetch_arb;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam int TO = 63;
    logic clk = 0, reset = 1, a_req = 0, b_req = 0, mem_ack = 0, mem_valid = 0;
    logic [AW-1:0] a_addr = '0, b_addr = '0, mem_addr;
    logic [DW-1:0] mem_data = '0, a_data, b_data;
    logic a_busy, a_valid, b_busy, b_valid, mem_req, timeout_err;
`ifdef M72_GFX_ARB_STATS_EN
    logic stat_clr = 0;
    logic [15:0] stat_a_wait, stat_b_wait;
    logic [7:0] stat_timeouts;
`endif
    m72_gfx_fetch_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK_32M(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_busy(a_busy), .a_data(a_data), .a_valid(a_valid),
        .b_req(b_req), .b_addr(b_addr), .b_busy(b_busy), .b_data(b_data), .b_valid(b_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .mem_valid(mem_valid), .timeout_err(timeout_err)
`ifdef M72_GFX_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_a_wait(stat_a_wait), .stat_b_wait(stat_b_wait),
        .stat_timeouts(stat_timeouts)
`endif
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    typedef struct {bit own; logic [AW-1:0] addr; logic [DW-1:0] data; bit tmo;} exp_t;
    exp_t exp_q[$];
    logic [AW-1:0] mem_log[$];
    int total = 0, bad = 0, ack_dly = 2, val_dly = 4, ack_cyc = 0;
    bit drop = 0, same = 0, stray = 0;
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a == 22'h012345 ? 32'hDEADBEEF : a == 22'h55 ? 32'h1 : {10'h3C5, a};
    endfunction
    // Memory model: ack ack_dly cycles after mem_req, data val_dly cycles after ack.
    initial begin
        logic [AW-1:0] ad;
        forever begin
            @(negedge clk);
            if (stray) begin
                mem_valid = 1; mem_data = 32'hBAD00BAD;
                @(negedge clk);
                mem_valid = 0; stray = 0;
            end else if (mem_req && !reset) begin
                ad = mem_addr;
                mem_log.push_back(ad);
                repeat (ack_dly) @(negedge clk);
                mem_ack = 1; ack_cyc = cyc;
                if (same) begin mem_valid = 1; mem_data = mem_word(ad); end
                @(negedge clk);
                mem_ack = 0; mem_valid = 0;
                if (!same && !drop) begin
                    repeat (val_dly - 1) @(negedge clk);
                    mem_valid = 1; mem_data = mem_word(ad);
                    @(negedge clk);
                    mem_valid = 0;
                end
            end
        end
    end
    task automatic req(input bit a, input bit b, input logic [AW-1:0] aa, input logic [AW-1:0] ba);
        @(negedge clk);
        a_req = a; b_req = b; a_addr = aa; b_addr = ba;
        @(negedge clk);
        a_req = 0; b_req = 0;
    endtask
    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = a_valid || b_valid;
        end
    endtask
    task automatic test_reset;
        reset = 1;
        repeat (3) @(negedge clk);
        total++;
        if ({mem_req, a_busy, b_busy, a_valid, b_valid, timeout_err} !== 6'b0) begin
            bad++; $display("FAIL reset_ctl: got %b want 000000", {mem_req, a_busy, b_busy, a_valid, b_valid, timeout_err});
        end
        total++;
        if ({a_data, b_data, mem_addr} !== '0) begin
            bad++; $display("FAIL reset_data: got a=%h b=%h addr=%h want 0", a_data, b_data, mem_addr);
        end
`ifdef M72_GFX_ARB_STATS_EN
        total++;
        if ({stat_a_wait, stat_b_wait, stat_timeouts} !== '0) begin
            bad++; $display("FAIL reset_stats: got %h %h %h want 0", stat_a_wait, stat_b_wait, stat_timeouts);
        end
`endif
        reset = 0;
    endtask
    task automatic test_single;
        bit ok = 0, prev = 0;
        exp_t e;
        logic [AW-1:0] ad;
        exp_q.push_back('{own: 0, addr: 22'h012345, data: 32'hDEADBEEF, tmo: 0});
        req(1, 0, 22'h012345, '0);
        for (int i = 0; i < 100 && !ok; i++) begin
            prev = a_busy;
            @(negedge clk);
            ok = a_valid || b_valid;
        end
        e = exp_q.pop_front();
        ad = mem_log.size() != 0 ? mem_log.pop_front() : 'x;
        total++;
        if (!ok || {b_valid, a_valid} !== 2'b01 || a_data !== e.data) begin
            bad++; $display("FAIL single_data: got v=%b a_data=%h want v=01 a_data=%h", {b_valid, a_valid}, a_data, e.data);
        end
        total++;
        if (ad !== e.addr) begin bad++; $display("FAIL single_addr: got %h want %h", ad, e.addr); end
        total++;
        if (prev !== 1'b1 || a_busy !== 1'b0) begin
            bad++; $display("FAIL single_busy: got before=%b at_valid=%b want 1 0", prev, a_busy);
        end
        @(negedge clk);
        total++;
        if ({b_valid, a_valid} !== 2'b00) begin bad++; $display("FAIL single_pulse: got %b want 00", {b_valid, a_valid}); end
    endtask
    task automatic test_simul;
        bit ok;
        exp_t e;
        logic [AW-1:0] ad;
        int n;
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        for (int r = 0; r < 3; r++) begin
            n = r == 1 ? 1 : 2;
            if (r == 0) begin
                exp_q.push_back('{own: 0, addr: 22'h100, data: mem_word(22'h100), tmo: 0});
                exp_q.push_back('{own: 1, addr: 22'h200, data: mem_word(22'h200), tmo: 0});
            end else if (r == 1) begin
                exp_q.push_back('{own: 0, addr: 22'h101, data: mem_word(22'h101), tmo: 0});
            end else begin
                exp_q.push_back('{own: 1, addr: 22'h202, data: mem_word(22'h202), tmo: 0});
                exp_q.push_back('{own: 0, addr: 22'h102, data: mem_word(22'h102), tmo: 0});
            end
            req(1, r != 1, 22'h100 + AW'(r), 22'h200 + AW'(r));
            for (int k = 0; k < n; k++) begin
                wait_valid(ok);
                e = exp_q.pop_front();
                ad = mem_log.size() != 0 ? mem_log.pop_front() : 'x;
                total++;
                if (!ok || {b_valid, a_valid} !== (e.own ? 2'b10 : 2'b01) || (e.own ? b_data : a_data) !== e.data || ad !== e.addr) begin
                    bad++;
                    $display("FAIL simul_r%0d_%0d: got v=%b a=%h b=%h addr=%h want own=%0d data=%h addr=%h",
                             r, k, {b_valid, a_valid}, a_data, b_data, ad, e.own, e.data, e.addr);
                end
            end
        end
    endtask
    task automatic test_dup;
        bit ok;
        int extra = 0;
        exp_t e;
        logic [AW-1:0] ad;
        exp_q.push_back('{own: 0, addr: 22'h10, data: mem_word(22'h10), tmo: 0});
        req(1, 0, 22'h10, '0);
        @(negedge clk);
        total++;
        if (a_busy !== 1'b1) begin bad++; $display("FAIL dup_busy: got %b want 1", a_busy); end
        req(1, 0, 22'h20, '0);
        wait_valid(ok);
        e = exp_q.pop_front();
        ad = mem_log.size() != 0 ? mem_log.pop_front() : 'x;
        total++;
        if (!ok || !a_valid || a_data !== e.data || ad !== e.addr) begin
            bad++; $display("FAIL dup_first: got v=%b data=%h addr=%h want 1 %h %h", a_valid, a_data, ad, e.data, e.addr);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (a_valid || b_valid || mem_req) extra++;
        end
        total++;
        if (extra != 0 || mem_log.size() != 0) begin
            bad++; $display("FAIL dup_extra: got %0d extra cycles %0d txns want 0 0", extra, mem_log.size());
        end
    endtask
    task automatic test_watchdog;
        bit ok;
        int late = 0;
        exp_t e;
        logic [AW-1:0] ad;
        drop = 1;
        exp_q.push_back('{own: 0, addr: 22'h77, data: '0, tmo: 1});
        req(1, 0, 22'h77, '0);
        wait_valid(ok);
        e = exp_q.pop_front();
        ad = mem_log.size() != 0 ? mem_log.pop_front() : 'x;
        total++;
        if (!ok || {b_valid, a_valid, timeout_err} !== 3'b011 || a_data !== e.data || ad !== e.addr) begin
            bad++; $display("FAIL wdog_resp: got v=%b err=%b data=%h addr=%h want 01 1 %h %h",
                            {b_valid, a_valid}, timeout_err, a_data, ad, e.data, e.addr);
        end
        total++;
        if (cyc - ack_cyc != TO) begin bad++; $display("FAIL wdog_delay: got %0d want %0d", cyc - ack_cyc, TO); end
        @(negedge clk);
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL wdog_pulse: got %b want 0", timeout_err); end
`ifdef M72_GFX_ARB_STATS_EN
        total++;
        if (stat_timeouts !== 8'd1) begin bad++; $display("FAIL wdog_stat: got %0d want 1", stat_timeouts); end
`endif
        repeat (8) @(negedge clk);
        stray = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_valid || b_valid || timeout_err) late++;
        end
        total++;
        if (late != 0 || a_data !== '0) begin bad++; $display("FAIL wdog_late: got %0d strobes data=%h want 0 0", late, a_data); end
        drop = 0;
    endtask
    task automatic test_same_cycle;
        bit ok;
        exp_t e;
        logic [AW-1:0] ad;
        same = 1;
        exp_q.push_back('{own: 1, addr: 22'h55, data: 32'h1, tmo: 0});
        req(0, 1, '0, 22'h55);
        wait_valid(ok);
        e = exp_q.pop_front();
        ad = mem_log.size() != 0 ? mem_log.pop_front() : 'x;
        total++;
        if (!ok || {b_valid, a_valid} !== 2'b10 || b_data !== e.data || ad !== e.addr) begin
            bad++; $display("FAIL same_resp: got v=%b data=%h addr=%h want 10 %h %h", {b_valid, a_valid}, b_data, ad, e.data, e.addr);
        end
        total++;
        if (cyc - ack_cyc != 1) begin bad++; $display("FAIL same_delay: got %0d want 1", cyc - ack_cyc); end
        same = 0;
        @(negedge clk);
    endtask
    task automatic test_back_to_back;
        bit ok;
        exp_t e;
        logic [AW-1:0] ad;
        exp_q.push_back('{own: 0, addr: 22'h300, data: mem_word(22'h300), tmo: 0});
        exp_q.push_back('{own: 1, addr: 22'h400, data: mem_word(22'h400), tmo: 0});
        exp_q.push_back('{own: 0, addr: 22'h301, data: mem_word(22'h301), tmo: 0});
        req(1, 1, 22'h300, 22'h400);
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok);
            e = exp_q.pop_front();
            ad = mem_log.size() != 0 ? mem_log.pop_front() : 'x;
            total++;
            if (!ok || {b_valid, a_valid} !== (e.own ? 2'b10 : 2'b01) || (e.own ? b_data : a_data) !== e.data || ad !== e.addr) begin
                bad++; $display("FAIL b2b_%0d: got v=%b a=%h b=%h addr=%h want own=%0d data=%h addr=%h",
                                k, {b_valid, a_valid}, a_data, b_data, ad, e.own, e.data, e.addr);
            end
            if (k == 0) begin
                a_req = 1; a_addr = 22'h301;
                @(negedge clk);
                a_req = 0;
                total++;
                if (mem_req !== 1'b1 || mem_addr !== 22'h400 || a_busy !== 1'b1) begin
                    bad++; $display("FAIL b2b_next: got req=%b addr=%h a_busy=%b want 1 400 1", mem_req, mem_addr, a_busy);
                end
            end
        end
    endtask
    task automatic test_reset_mid;
        int late = 0;
        drop = 1;
        req(1, 0, 22'h500, '0);
        repeat (8) @(negedge clk);
        req(0, 1, '0, 22'h600);
        total++;
        if ({a_busy, b_busy, mem_req} !== 3'b110) begin
            bad++; $display("FAIL rmid_pre: got busy=%b%b req=%b want 11 0", a_busy, b_busy, mem_req);
        end
        reset = 1;
        @(negedge clk);
        total++;
        if ({mem_req, a_busy, b_busy} !== 3'b000) begin
            bad++; $display("FAIL rmid_clear: got req=%b busy=%b%b want 0 00", mem_req, a_busy, b_busy);
        end
`ifdef M72_GFX_ARB_STATS_EN
        total++;
        if ({stat_a_wait, stat_b_wait, stat_timeouts} !== '0) begin
            bad++; $display("FAIL rmid_stats: got %0d %0d %0d want 0", stat_a_wait, stat_b_wait, stat_timeouts);
        end
`endif
        @(negedge clk);
        reset = 0;
        mem_log.delete();
        stray = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_valid || b_valid || mem_req || timeout_err) late++;
        end
        total++;
        if (late != 0 || a_data !== '0) begin bad++; $display("FAIL rmid_stray: got %0d strobes data=%h want 0 0", late, a_data); end
        drop = 0;
    endtask
    initial begin
        test_reset();
        test_single();
        test_simul();
        test_dup();
        test_watchdog();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end
endmodule
